// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor: timing states, opcodes,
// ALU codes and bus-select bit positions.
package proc_pkg;

   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_SLT = 2'b11;

   localparam int SEL_DIN = 9;
   localparam int SEL_R0  = 8;
   localparam int SEL_G   = 0;

   localparam int IR_W   = 9;
   localparam int CTRL_W = 10;

   function automatic logic is_alu(input logic [2:0] op);
      return (op >= OP_ADD) && (op <= OP_SLT);
   endfunction

endpackage

// File: rtl/proc_control_unit_if.sv
// Handshake/bus bundle between the instruction sequencer and the datapath.
interface proc_control_unit_if #(parameter int DATA_W = 16);
   import proc_pkg::*;

   logic                Run;
   logic [DATA_W-1:0]   DIN;
   logic [IR_W-1:0]     IR;
   logic [CTRL_W-1:0]   control;
   logic [7:0]          Rin;
   logic                IRin;
   logic                Ain;
   logic                Gin;
   logic [1:0]          alu_op;
   logic                Done;

   modport master (input Run, DIN,
                   output IR, control, Rin, IRin, Ain, Gin, alu_op, Done);
   modport slave  (output Run, DIN,
                   input IR, control, Rin, IRin, Ain, Gin, alu_op, Done);
endinterface

// File: rtl/dec3to8.sv
// 3-bit index to 8-bit one-hot decoder with enable.
module dec3to8 (
   input  logic [2:0] idx,
   input  logic       en,
   output logic [7:0] y
);
   always_comb y = en ? (8'b1 << idx) : 8'b0;
endmodule

// File: rtl/proc_control_unit.sv
// Instruction sequencer: fetches IR in T0, then walks T1..T3 driving register
// enables, ALU op and the one-hot bus select.
module proc_control_unit
   import proc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   proc_control_unit_if.master  bus
);
   localparam int RW = $clog2(NREGS);

   state_t          state, nstate;
   logic [IR_W-1:0] ir;
   logic [2:0]      op;
   logic [RW-1:0]   rx, ry, sel_idx;
   logic            rin_en, sel_reg_en, sel_din, sel_g;
   logic            irin, ain, gin, done;
   logic [1:0]      alu;
   logic [7:0]      rin, sel_oh;
   logic [CTRL_W-1:0] control;
   logic            unused_din;

   assign op = ir[8:6];
   assign rx = ir[5:3];
   assign ry = ir[2:0];
   assign unused_din = ^bus.DIN[DATA_W-IR_W-1:0];

   always_ff @(posedge Clock) begin
      if (Reset) state <= T0;
      else       state <= nstate;
   end

   // irin is already forced low under reset, so reset has priority here
   always_ff @(posedge Clock) begin
      if (Reset)     ir <= '0;
      else if (irin) ir <= bus.DIN[DATA_W-1 -: IR_W];
   end

   always_comb begin
      nstate = state;
      case (state)
         T0: if (bus.Run) nstate = T1;
         T1: nstate = is_alu(op) ? T2 : T0;
         T2: nstate = is_alu(op) ? T3 : T0;
         T3: nstate = T0;
         default: nstate = T0;
      endcase
   end

   always_comb begin
      rin_en     = 1'b0;
      sel_reg_en = 1'b0;
      sel_idx    = rx;
      sel_din    = 1'b0;
      sel_g      = 1'b0;
      irin       = 1'b0;
      ain        = 1'b0;
      gin        = 1'b0;
      alu        = ALU_ADD;
      done       = 1'b0;
      if (!Reset) begin
         case (state)
            T0: irin = bus.Run;
            T1: begin
               case (op)
                  OP_MV: begin
                     sel_reg_en = 1'b1;
                     sel_idx    = ry;
                     rin_en     = 1'b1;
                     done       = 1'b1;
                  end
                  OP_MVI: begin
                     sel_din = 1'b1;
                     rin_en  = 1'b1;
                     done    = 1'b1;
                  end
                  OP_ADD, OP_SUB, OP_AND, OP_SLT: begin
                     sel_reg_en = 1'b1;
                     ain        = 1'b1;
                  end
                  default: done = 1'b1;
               endcase
            end
            T2: begin
               sel_reg_en = 1'b1;
               sel_idx    = ry;
               gin        = 1'b1;
               alu        = 2'(op - OP_ADD);
            end
            T3: begin
               sel_g  = 1'b1;
               rin_en = 1'b1;
               done   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   dec3to8 u_rin (.idx(rx),      .en(rin_en),     .y(rin));
   dec3to8 u_sel (.idx(sel_idx), .en(sel_reg_en), .y(sel_oh));

   // register selects sit bit-reversed in control[8:1]: R0 at bit 8, R7 at bit 1
   always_comb begin
      control          = '0;
      control[SEL_DIN] = sel_din;
      control[SEL_G]   = sel_g;
      for (int k = 0; k < 8; k++) control[SEL_R0-k] = sel_oh[k];
   end

   assign bus.IR      = ir;
   assign bus.control = control;
   assign bus.Rin     = rin;
   assign bus.IRin    = irin;
   assign bus.Ain     = ain;
   assign bus.Gin     = gin;
   assign bus.alu_op  = alu;
   assign bus.Done    = done;
endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench for proc_control_unit: per-cycle expected outputs queued at drive time.
module tb_proc_control_unit;
   import proc_pkg::*;

   typedef struct packed {
      logic [9:0] ctrl;
      logic [7:0] rin;
      logic       irin, ain, gin;
      logic [1:0] op;
      logic       done;
   } exp_t;

   typedef struct packed {
      exp_t       o;
      logic [8:0] ir;
   } obs_t;

   typedef struct packed {
      logic        rst, run;
      logic [15:0] din;
      exp_t        e;
   } stim_t;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   always #5 Clock = ~Clock;

   proc_control_unit_if #(.DATA_W(16)) bus();
   proc_control_unit #(.DATA_W(16), .NREGS(8)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

   obs_t       exp_q[$];
   logic [8:0] ir_model = 9'b0;
   int         n_asrt = 0;
   int         n_fail = 0;

   function automatic stim_t st(input logic rst, input logic run, input logic [15:0] din,
                                input logic [9:0] ctrl, input logic [7:0] rin,
                                input logic irin, input logic ain, input logic gin,
                                input logic [1:0] op, input logic done);
      stim_t s;
      s.rst = rst; s.run = run; s.din = din;
      s.e = '{ctrl: ctrl, rin: rin, irin: irin, ain: ain, gin: gin, op: op, done: done};
      return s;
   endfunction

   function automatic logic [15:0] ins(input logic [2:0] o, input logic [2:0] x, input logic [2:0] y);
      return {o, x, y, 7'h00};
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o = {bus.control, bus.Rin, bus.IRin, bus.Ain, bus.Gin, bus.alu_op, bus.Done, bus.IR};
      return o;
   endfunction

   // drive one cycle and queue what the outputs must look like during it
   task automatic drive(input stim_t s);
      obs_t e;
      @(posedge Clock);
      #1;
      Reset   = s.rst;
      bus.Run = s.run;
      bus.DIN = s.din;
      e.o  = s.e;
      e.ir = ir_model;
      exp_q.push_back(e);
      if (s.rst)         ir_model = 9'b0;
      else if (s.e.irin) ir_model = s.din[15:7];
   endtask

   task automatic test_reset();
      stim_t s[$];
      obs_t got, ex;
      s.push_back(st(1, 1, ins(OP_MVI, 3'd2, 3'd0), 10'b0, 8'b0, 0, 0, 0, 2'b00, 0));
      s.push_back(st(1, 1, ins(OP_MVI, 3'd2, 3'd0), 10'b0, 8'b0, 0, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0,                   10'b0, 8'b0, 0, 0, 0, 2'b00, 0));
      foreach (s[i]) begin
         drive(s[i]);
         @(negedge Clock);
         got = observe();
         ex = exp_q.pop_front();
         n_asrt++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL reset[%0d] got=%b expected=%b", i, got, ex);
         end
      end
   endtask

   task automatic test_mvi_mv();
      stim_t s[$];
      obs_t got, ex;
      s.push_back(st(0, 1, ins(OP_MVI, 3'd2, 3'd0), 10'b0,          8'b0,        1, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'hBEEF,                10'b1000000000, 8'b00000100, 0, 0, 0, 2'b00, 1));
      s.push_back(st(0, 0, 16'h0,                   10'b0,          8'b0,        0, 0, 0, 2'b00, 0));
      s.push_back(st(0, 1, ins(OP_MV, 3'd5, 3'd1),  10'b0,          8'b0,        1, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0,                   10'b0010000000, 8'b00100000, 0, 0, 0, 2'b00, 1));
      s.push_back(st(0, 0, 16'h0,                   10'b0,          8'b0,        0, 0, 0, 2'b00, 0));
      s.push_back(st(0, 1, ins(OP_MV, 3'd3, 3'd3),  10'b0,          8'b0,        1, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0,                   10'b0000100000, 8'b00001000, 0, 0, 0, 2'b00, 1));
      s.push_back(st(0, 0, 16'h0,                   10'b0,          8'b0,        0, 0, 0, 2'b00, 0));
      foreach (s[i]) begin
         drive(s[i]);
         @(negedge Clock);
         got = observe();
         ex = exp_q.pop_front();
         n_asrt++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL mvi_mv[%0d] got=%b expected=%b", i, got, ex);
         end
      end
   endtask

   task automatic test_alu();
      stim_t s[$];
      obs_t got, ex;
      // sub R0,R7
      s.push_back(st(0, 1, ins(OP_SUB, 3'd0, 3'd7), 10'b0,          8'b0,        1, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0, 10'b0100000000, 8'b0,        0, 1, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0, 10'b0000000010, 8'b0,        0, 0, 1, 2'b01, 0));
      s.push_back(st(0, 0, 16'h0, 10'b0000000001, 8'b00000001, 0, 0, 0, 2'b00, 1));
      // add R3,R3
      s.push_back(st(0, 1, ins(OP_ADD, 3'd3, 3'd3), 10'b0,          8'b0,        1, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0, 10'b0000100000, 8'b0,        0, 1, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0, 10'b0000100000, 8'b0,        0, 0, 1, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0, 10'b0000000001, 8'b00001000, 0, 0, 0, 2'b00, 1));
      // and R6,R4
      s.push_back(st(0, 1, ins(OP_AND, 3'd6, 3'd4), 10'b0,          8'b0,        1, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0, 10'b0000000100, 8'b0,        0, 1, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0, 10'b0000010000, 8'b0,        0, 0, 1, 2'b10, 0));
      s.push_back(st(0, 0, 16'h0, 10'b0000000001, 8'b01000000, 0, 0, 0, 2'b00, 1));
      // slt R2,R6
      s.push_back(st(0, 1, ins(OP_SLT, 3'd2, 3'd6), 10'b0,          8'b0,        1, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0, 10'b0001000000, 8'b0,        0, 1, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0, 10'b0000000100, 8'b0,        0, 0, 1, 2'b11, 0));
      s.push_back(st(0, 0, 16'h0, 10'b0000000001, 8'b00000100, 0, 0, 0, 2'b00, 1));
      s.push_back(st(0, 0, 16'h0, 10'b0,          8'b0,        0, 0, 0, 2'b00, 0));
      foreach (s[i]) begin
         drive(s[i]);
         @(negedge Clock);
         got = observe();
         ex = exp_q.pop_front();
         n_asrt++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL alu[%0d] got=%b expected=%b", i, got, ex);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t s[$];
      obs_t got, ex;
      s.push_back(st(0, 1, ins(OP_MVI, 3'd7, 3'd0), 10'b0,          8'b0,        1, 0, 0, 2'b00, 0));
      s.push_back(st(0, 1, 16'h1234,                10'b1000000000, 8'b10000000, 0, 0, 0, 2'b00, 1));
      s.push_back(st(0, 1, ins(OP_ADD, 3'd1, 3'd2), 10'b0,          8'b0,        1, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'hFFFF,                10'b0010000000, 8'b0,        0, 1, 0, 2'b00, 0));
      s.push_back(st(0, 1, ins(OP_MV, 3'd4, 3'd4),  10'b0001000000, 8'b0,        0, 0, 1, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0,                   10'b0000000001, 8'b00000010, 0, 0, 0, 2'b00, 1));
      s.push_back(st(0, 0, 16'h0,                   10'b0,          8'b0,        0, 0, 0, 2'b00, 0));
      foreach (s[i]) begin
         drive(s[i]);
         @(negedge Clock);
         got = observe();
         ex = exp_q.pop_front();
         n_asrt++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL back_to_back[%0d] got=%b expected=%b", i, got, ex);
         end
      end
   endtask

   task automatic test_reset_mid_nop();
      stim_t s[$];
      obs_t got, ex;
      s.push_back(st(0, 1, ins(OP_SLT, 3'd4, 3'd5), 10'b0,          8'b0, 1, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0,                   10'b0000010000, 8'b0, 0, 1, 0, 2'b00, 0));
      s.push_back(st(1, 1, 16'h0,                   10'b0,          8'b0, 0, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0,                   10'b0,          8'b0, 0, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0,                   10'b0,          8'b0, 0, 0, 0, 2'b00, 0));
      s.push_back(st(0, 1, ins(3'b110, 3'd1, 3'd2), 10'b0,          8'b0, 1, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0,                   10'b0,          8'b0, 0, 0, 0, 2'b00, 1));
      s.push_back(st(0, 0, 16'h0,                   10'b0,          8'b0, 0, 0, 0, 2'b00, 0));
      s.push_back(st(0, 1, ins(3'b111, 3'd6, 3'd0), 10'b0,          8'b0, 1, 0, 0, 2'b00, 0));
      s.push_back(st(0, 0, 16'h0,                   10'b0,          8'b0, 0, 0, 0, 2'b00, 1));
      s.push_back(st(0, 0, 16'h0,                   10'b0,          8'b0, 0, 0, 0, 2'b00, 0));
      foreach (s[i]) begin
         drive(s[i]);
         @(negedge Clock);
         got = observe();
         ex = exp_q.pop_front();
         n_asrt++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL reset_mid_nop[%0d] got=%b expected=%b", i, got, ex);
         end
      end
   endtask

   initial begin
      bus.Run = 1'b1;
      bus.DIN = 16'h0;
      test_reset();
      test_mvi_mv();
      test_alu();
      test_back_to_back();
      test_reset_mid_nop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
